pipe_skid_reg: RTL and testbench

//  Elastic 2-entry pipeline register between datapath stages; the flow-controlled

---
 rtl/skid_pkg.sv | 13 +
 rtl/sat_counter.sv | 19 +
 rtl/pipe_skid_reg.sv | 103 ++++++++++
 tb/tb_pipe_skid_reg.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/skid_pkg.sv
// Shared constants and state encoding for the elastic skid pipeline register.
package skid_pkg;

    localparam int SKID_WIDTH = 8;
    localparam int SKID_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry elastic pipeline register with registered valid/ready on both sides.
// Define SKID_STATS_EN to build the saturating output-stall counter on stall_cnt.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | nothing held; m_valid=0, s_ready=1
// ST_BUSY  | one word in main reg; m_valid=1, s_ready=1
// ST_FULL  | main and skid regs hold words; m_valid=1, s_ready=0
module pipe_skid_reg
    import skid_pkg::*;
#(
    parameter int WIDTH = SKID_WIDTH,
    parameter int CNT_W = SKID_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] stall_cnt
);

    skid_state_t      state, state_nxt;
    logic [WIDTH-1:0] main_q, main_nxt;
    logic [WIDTH-1:0] skid_q, skid_nxt;
    logic             in_xfer, out_xfer;

    assign in_xfer  = s_valid & s_ready;
    assign out_xfer = m_valid & m_ready;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        main_nxt  = s_data;
                        state_nxt = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_xfer && out_xfer) begin
                        main_nxt = s_data;
                    end else if (in_xfer) begin
                        skid_nxt  = s_data;
                        state_nxt = ST_FULL;
                    end else if (out_xfer) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        main_nxt  = skid_q;
                        state_nxt = ST_BUSY;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Handshake outputs are flopped from the next state so neither depends on inputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
        end else begin
            state   <= state_nxt;
            main_q  <= main_nxt;
            skid_q  <= skid_nxt;
            m_valid <= (state_nxt == ST_BUSY) || (state_nxt == ST_FULL);
            s_ready <= (state_nxt != ST_FULL);
        end
    end

    assign m_data = main_q;

`ifdef SKID_STATS_EN
    logic stall_inc;
    assign stall_inc = m_valid & ~m_ready;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .cnt   (stall_cnt)
    );
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios plus random traffic
// checked against a queue-based occupancy model.
module tb_pipe_skid_reg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
    localparam int STALL_MAX = (1 << CNT_W) - 1;
`ifdef SKID_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset, flush, s_valid, s_ready, m_valid, m_ready;
    logic [WIDTH-1:0] s_data, m_data;
    logic [CNT_W-1:0] stall_cnt;

    int               pass_cnt = 0;
    int               total_cnt = 0;
    logic [WIDTH-1:0] q[$];
    int               stall_m = 0;

    pipe_skid_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the reference model at the edge, return at negedge.
    task automatic tick(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
        s_valid = v;
        s_data  = d;
        m_ready = r;
        flush   = f;
        @(posedge clk);
        if (STATS && q.size() > 0 && !r && stall_m < STALL_MAX) stall_m++;
        if (f) begin
            q.delete();
        end else begin
            bit out_x = r && (q.size() > 0);
            bit in_x  = v && (q.size() < 2);
            if (out_x) void'(q.pop_front());
            if (in_x) q.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        flush   = 1'b0;
        q.delete();
        stall_m = 0;
        #2 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b0;
        q.delete();
        stall_m = 0;
        #2;
        total_cnt++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 8'h00 || stall_cnt !== 4'h0)
            $display("FAIL reset_hold: got v=%b r=%b d=%h c=%h expected v=0 r=1 d=00 c=0", m_valid, s_ready, m_data, stall_cnt);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 8'h00)
            $display("FAIL reset_edge: got v=%b r=%b d=%h expected v=0 r=1 d=00", m_valid, s_ready, m_data);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b0;
        #4;
        total_cnt++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 8'h00)
            $display("FAIL reset_release: got v=%b r=%b d=%h expected v=0 r=1 d=00", m_valid, s_ready, m_data);
        else pass_cnt++;
        @(posedge clk);
        q.push_back(8'hA5);
        @(negedge clk);
        total_cnt++;
        if (m_valid !== 1'b1 || m_data !== q[0])
            $display("FAIL reset_first_xfer: got v=%b d=%h expected v=1 d=%h", m_valid, m_data, q[0]);
        else pass_cnt++;
        s_valid = 1'b0;
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            tick(1'b1, WIDTH'(i), 1'b1, 1'b0);
            total_cnt++;
            if (m_valid !== 1'b1 || m_data !== WIDTH'(i))
                $display("FAIL stream_%0d: got v=%b d=%h expected v=1 d=%h", i, m_valid, m_data, WIDTH'(i));
            else pass_cnt++;
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        total_cnt++;
        if (m_valid !== 1'b0)
            $display("FAIL stream_drain: got v=%b expected v=0", m_valid);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] exp_out [3];
        exp_out[0] = 8'h11; exp_out[1] = 8'h22; exp_out[2] = 8'h33;
        do_reset();
        tick(1'b1, 8'h11, 1'b0, 1'b0);
        total_cnt++;
        if (s_ready !== 1'b1)
            $display("FAIL bp_ready_after_11: got %b expected 1", s_ready);
        else pass_cnt++;
        tick(1'b1, 8'h22, 1'b0, 1'b0);
        total_cnt++;
        if (s_ready !== 1'b0)
            $display("FAIL bp_ready_after_22: got %b expected 0", s_ready);
        else pass_cnt++;
        tick(1'b1, 8'h33, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            total_cnt++;
            if (m_valid !== 1'b1 || m_data !== exp_out[i])
                $display("FAIL bp_out_%0d: got v=%b d=%h expected v=1 d=%h", i, m_valid, m_data, exp_out[i]);
            else pass_cnt++;
            tick(1'b1, 8'h33, 1'b1, 1'b0);
            if (q.size() == 2) s_valid = 1'b1;
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        total_cnt++;
        if (m_valid !== 1'b0 || q.size() != 0)
            $display("FAIL bp_drain: got v=%b expected v=0 (model depth %0d)", m_valid, q.size());
        else pass_cnt++;
    endtask

    task automatic test_flush();
        do_reset();
        tick(1'b1, 8'h55, 1'b0, 1'b0);
        tick(1'b1, 8'h66, 1'b0, 1'b0);
        tick(1'b1, 8'h44, 1'b0, 1'b1);
        total_cnt++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1)
            $display("FAIL flush_full: got v=%b r=%b expected v=0 r=1", m_valid, s_ready);
        else pass_cnt++;
        tick(1'b1, 8'h77, 1'b0, 1'b0);
        tick(1'b1, 8'h44, 1'b1, 1'b1);
        total_cnt++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1)
            $display("FAIL flush_busy: got v=%b r=%b expected v=0 r=1", m_valid, s_ready);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, 1'b1, 1'b0);
            total_cnt++;
            if (m_valid !== 1'b0)
                $display("FAIL flush_no_leak_%0d: got v=%b d=%h expected v=0", i, m_valid, m_data);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1'b1, 8'h81, 1'b0, 1'b0);
        tick(1'b1, 8'h82, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        total_cnt++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 8'h00)
            $display("FAIL async_reset: got v=%b r=%b d=%h expected v=0 r=1 d=00", m_valid, s_ready, m_data);
        else pass_cnt++;
        q.delete();
        stall_m = 0;
        s_valid = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_stall_cnt();
        do_reset();
        tick(1'b1, 8'h99, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            tick(1'b0, '0, 1'b0, 1'b0);
            if (i == 5) begin
                total_cnt++;
                if (stall_cnt !== CNT_W'(stall_m))
                    $display("FAIL stall_cnt_5: got %0d expected %0d", stall_cnt, stall_m);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (stall_cnt !== (STATS ? 4'hF : 4'h0))
            $display("FAIL stall_cnt_sat: got %h expected %h", stall_cnt, (STATS ? 4'hF : 4'h0));
        else pass_cnt++;
        tick(1'b0, '0, 1'b0, 1'b1);
        total_cnt++;
        if (stall_cnt !== CNT_W'(stall_m))
            $display("FAIL stall_cnt_flush: got %0d expected %0d", stall_cnt, stall_m);
        else pass_cnt++;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic v, r, f;
            logic [WIDTH-1:0] d;
            v = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 31) == 0);
            d = WIDTH'($urandom);
            tick(v, d, r, f);
            total_cnt++;
            if (m_valid !== (q.size() > 0) || s_ready !== (q.size() < 2))
                $display("FAIL rand_hs_%0d: got v=%b r=%b expected depth %0d", i, m_valid, s_ready, q.size());
            else pass_cnt++;
            if (q.size() > 0) begin
                total_cnt++;
                if (m_data !== q[0])
                    $display("FAIL rand_data_%0d: got %h expected %h", i, m_data, q[0]);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (stall_cnt !== CNT_W'(stall_m))
            $display("FAIL rand_stall_cnt: got %0d expected %0d", stall_cnt, stall_m);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_stall_cnt();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
